// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_4 (with helper decoder_2_4)
//  Purpose  : Four-requester round-robin arbiter with an optional hold limit
//             and a one-cycle dead gap between successive owners.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  decoder_2_4 : 2-to-4 one-hot decoder with enable; all-zero when disabled.
// ----------------------------------------------------------------------------
module decoder_2_4 (
  input  logic [1:0] a,
  input  logic       en,
  output logic [3:0] y
);

  // One-hot decode of the index, forced to zero while not enabled
  always_comb begin
    y = 4'b0000;
    if (en) begin
      y = 4'b0001 << a;
    end
  end

endmodule

// ----------------------------------------------------------------------------
//  rr_arbiter_4 : owner index / valid / preempt are registered; the one-hot
//  grant vector is derived from them through decoder_2_4 only.
// ----------------------------------------------------------------------------
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,  // max consecutive grant cycles; 0 = unlimited
  parameter int HOLD_W   = 5    // hold counter width; MAX_HOLD < 2**HOLD_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Hold limit is reached when the counter shows the last allowed cycle
  localparam bit                C_LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] C_CNT_MAX   = {HOLD_W{1'b1}};

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [1:0]        gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              preempt_q, preempt_d;

  logic              sel_found;
  logic [1:0]        sel_idx;
  logic [1:0]        cand;
  logic              owner_req;
  logic              hit_limit;

  // Circular priority search starting at the rotation pointer
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and registered-output computation for the ownership FSM
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    owner_req   = req[gnt_idx_q];
    hit_limit   = C_LIMIT_EN && (cnt_q == C_HOLD_LAST);

    case (state_q)
      ST_GRANT: begin
        cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (!owner_req || hit_limit) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 2'd1;
          state_d     = ST_GAP;
          // Only a forced removal of a still-requesting owner is a preemption
          preempt_d   = owner_req;
        end
      end
      default: begin
        // IDLE and GAP both arbitrate; GAP has already spent its dead cycle
        gnt_valid_d = 1'b0;
        state_d     = ST_IDLE;
        if (sel_found) begin
          gnt_idx_d   = sel_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_GRANT;
        end
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops any grant
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

  decoder_2_4 u_dec (
    .a  (gnt_idx_q),
    .en (gnt_valid_q),
    .y  (gnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter_4
//  Purpose  : Directed-vector bench for rr_arbiter_4 (MAX_HOLD=4) with a
//             queue-based scoreboard and an independent output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_4;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  typedef struct packed {
    logic [3:0]  gnt;
    logic        pre;
    int unsigned id;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  int unsigned step_id;

  rr_arbiter_4 #(
    .MAX_HOLD (4),
    .HOLD_W   (5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int unsigned id,
                     input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, id, got, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge
  task automatic step(input logic rn, input logic [3:0] r,
                      input logic [3:0] eg, input logic ep);
    exp_t e;
    @(negedge clk);
    reset_n = rn;
    req     = r;
    e.gnt   = eg;
    e.pre   = ep;
    e.id    = step_id;
    step_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",       e.id, gnt, e.gnt);
        chk("gnt_valid", e.id, {3'b000, gnt_valid}, {3'b000, |e.gnt});
        chk("preempt",   e.id, {3'b000, preempt}, {3'b000, e.pre});
        if (|e.gnt) begin
          chk("gnt_idx", e.id, {2'b00, gnt_idx}, {2'b00, onehot_idx(e.gnt)});
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    checks  = 0;
    errors  = 0;
    step_id = 0;
    reset_n = 1'b0;
    req     = 4'b1111;

    // Reset held two cycles with all clients requesting
    step(1'b0, 4'b1111, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 4'b0000, 1'b0);

    // Single requester from idle, then release through one gap cycle
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // Re-align the pointer to 0, then full rotation 0,1,2,3,0 under the hold limit
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, 4'b1111, 4'b0001 << (k % 4), 1'b0);
      end
      step(1'b1, 4'b1111, 4'b0000, 1'b1);
    end

    // Early release by owner 1 while 3 waits: 2 is skipped, no preempt
    step(1'b1, 4'b1010, 4'b0010, 1'b0);
    step(1'b1, 4'b1010, 4'b0010, 1'b0);
    step(1'b1, 4'b1000, 4'b0000, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // Sole hog: period of five (four granted, one preempt gap)
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, 4'b0001, 4'b0001, 1'b0);
      end
      step(1'b1, 4'b0001, 4'b0000, 1'b1);
    end

    // Request drop coinciding with the hold limit is a normal release
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 4'b0001, 4'b0001, 1'b0);
    end
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // Reset during owner 2's grant, then client 0 wins from pointer 0
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b0, 4'b0101, 4'b0000, 1'b0);
    step(1'b1, 4'b0101, 4'b0001, 1'b0);
    step(1'b1, 4'b0101, 4'b0001, 1'b0);
    step(1'b1, 4'b0100, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // Let the monitor drain the queue within a bounded number of cycles
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
